// File: rtl/top_pkg.sv
// Shared definitions for the single-cycle RV32I-subset core: opcodes,
// control-field encodings, memory depth and the arithmetic funct3 decode.
package top_pkg;

  localparam int unsigned MEM_DEPTH = 64;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_ITYPE  = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // funct3 values shared by R-type and I-type arithmetic
  function automatic logic arith_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
  endfunction

  function automatic alu_ctrl_e arith_f3_alu(input logic [2:0] f3, input logic sub);
    alu_ctrl_e sel;
    case (f3)
      3'b111:  sel = ALU_AND;
      3'b110:  sel = ALU_OR;
      3'b010:  sel = ALU_SLT;
      default: sel = sub ? ALU_SUB : ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/top_if.sv
// Control bundle between the instruction decoder (master) and the datapath
// (slave): instruction fields go in, control signals come out.
interface top_ctrl_if;
  import top_pkg::*;

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        reg_write;
  logic        mem_write;
  logic        alu_src;
  logic        branch;
  logic        jump;
  logic        lui_sel;
  imm_src_e    imm_src;
  result_src_e result_src;
  alu_ctrl_e   alu_ctrl;

  modport master (
    input  op, funct3, funct7,
    output reg_write, mem_write, alu_src, branch, jump, lui_sel,
           imm_src, result_src, alu_ctrl
  );

  modport slave (
    output op, funct3, funct7,
    input  reg_write, mem_write, alu_src, branch, jump, lui_sel,
           imm_src, result_src, alu_ctrl
  );
endinterface

// File: rtl/top_controller.sv
// Instruction decoder: opcode/funct3/funct7 to datapath control signals.
// Anything not recognised decodes to all-zero controls, i.e. a NOP.
// Optional: define RV_LUI_EN to decode lui.
module riscv_controller
  import top_pkg::*;
(
  top_ctrl_if.master ctrl
);

  // Combinational decode with NOP defaults
  always_comb begin
    ctrl.reg_write  = 1'b0;
    ctrl.mem_write  = 1'b0;
    ctrl.alu_src    = 1'b0;
    ctrl.branch     = 1'b0;
    ctrl.jump       = 1'b0;
    ctrl.lui_sel    = 1'b0;
    ctrl.imm_src    = IMM_I;
    ctrl.result_src = RES_ALU;
    ctrl.alu_ctrl   = ALU_ADD;
    case (ctrl.op)
      OP_LOAD: if (ctrl.funct3 == 3'b010) begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: if (ctrl.funct3 == 3'b010) begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
      end
      OP_RTYPE: if (arith_f3_ok(ctrl.funct3) &&
                    (ctrl.funct7 == 7'b0000000 ||
                     (ctrl.funct7 == 7'b0100000 && ctrl.funct3 == 3'b000))) begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = arith_f3_alu(ctrl.funct3, ctrl.funct7[5]);
      end
      OP_ITYPE: if (arith_f3_ok(ctrl.funct3)) begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = arith_f3_alu(ctrl.funct3, 1'b0);
      end
      OP_BRANCH: if (ctrl.funct3 == 3'b000) begin
        ctrl.branch   = 1'b1;
        ctrl.imm_src  = IMM_B;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
      end
`ifdef RV_LUI_EN
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.lui_sel   = 1'b1;
      end
`else
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/top.sv
// Single-cycle RV32I-subset core: PC, instruction ROM, register file, ALU
// and data RAM, with decoding delegated to riscv_controller.
// Optional: define RV_LUI_EN to add lui (decoded in riscv_controller).
module top
  import top_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] WriteData,
  output logic [31:0] ALUResult,
  output logic        MemWrite
);

  localparam int unsigned ADDR_W   = $clog2(MEM_DEPTH);
  localparam int unsigned REF_SIZE = 21;

  localparam logic [31:0] REF_PROG [REF_SIZE] = '{
    32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233,
    32'h0041F2B3, 32'h004282B3, 32'h02728863, 32'h0041A233,
    32'h00020463, 32'h00000293, 32'h0023A233, 32'h005203B3,
    32'h402383B3, 32'h0471AA23, 32'h06002103, 32'h005104B3,
    32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
    32'h00210063
  };

  logic [31:0] imem [MEM_DEPTH];
  logic [31:0] dmem [MEM_DEPTH];
  logic [31:0] rf   [32];

  logic [31:0] pc, pc_plus4, pc_target, pc_next;
  logic [31:0] instr, imm_ext, src_a, src_b, rd1, read_data, result;
  logic [4:0]  rs1, rs2, rd;
  logic        zero, pc_src;

  top_ctrl_if ctrl ();

  riscv_controller u_ctrl (.ctrl(ctrl.master));

  // Reference program image held inline in place of the external hex file
  initial begin
    for (int unsigned i = 0; i < MEM_DEPTH; i++)
      imem[i] = (i < REF_SIZE) ? REF_PROG[i] : '0;
  end

  assign instr       = imem[pc[ADDR_W+1:2]];
  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign rd          = instr[11:7];
  assign ctrl.op     = instr[6:0];
  assign ctrl.funct3 = instr[14:12];
  assign ctrl.funct7 = instr[31:25];

  assign rd1       = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign WriteData = (rs2 == 5'd0) ? '0 : rf[rs2];

  // Immediate generation; lui overrides the type-based selection
  always_comb begin
    imm_ext = '0;
    case (ctrl.imm_src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
    if (ctrl.lui_sel) imm_ext = {instr[31:12], 12'b0};
  end

  assign src_a = ctrl.lui_sel ? '0 : rd1;
  assign src_b = ctrl.alu_src ? imm_ext : WriteData;

  // ALU
  always_comb begin
    ALUResult = '0;
    case (ctrl.alu_ctrl)
      ALU_ADD: ALUResult = src_a + src_b;
      ALU_SUB: ALUResult = src_a - src_b;
      ALU_AND: ALUResult = src_a & src_b;
      ALU_OR:  ALUResult = src_a | src_b;
      ALU_SLT: ALUResult = {31'b0, $signed(src_a) < $signed(src_b)};
      default: ALUResult = '0;
    endcase
  end

  assign zero      = (ALUResult == 32'd0);
  assign read_data = dmem[ALUResult[ADDR_W+1:2]];
  assign MemWrite  = ctrl.mem_write & rst;

  // Writeback source select
  always_comb begin
    result = '0;
    case (ctrl.result_src)
      RES_ALU: result = ALUResult;
      RES_MEM: result = read_data;
      RES_PC4: result = pc_plus4;
      default: result = '0;
    endcase
  end

  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm_ext;
  assign pc_src    = ctrl.jump | (ctrl.branch & zero);
  assign pc_next   = pc_src ? pc_target : pc_plus4;

  // Program counter with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) pc <= '0;
    else      pc <= pc_next;
  end

  // Register file write port; x0 is never written, nothing written in reset
  always_ff @(posedge clk) begin
    if (rst && ctrl.reg_write && rd != 5'd0) rf[rd] <= result;
  end

  // Data RAM write port; addresses wrap modulo 256
  always_ff @(posedge clk) begin
    if (MemWrite) dmem[ALUResult[ADDR_W+1:2]] <= WriteData;
  end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: programs are placed in the instruction ROM,
// expected stores are queued up front and matched against observed stores.
module tb_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] WriteData, ALUResult;
  logic        MemWrite;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  store_t      exp_q[$];
  store_t      obs_q[$];
  logic [31:0] prog[$];

  localparam logic [31:0] HALT = 32'h00000063;  // beq x0,x0,0
  localparam logic [31:0] NOP  = 32'h00000013;  // addi x0,x0,0

  top dut (
    .clk       (clk),
    .rst       (rst),
    .WriteData (WriteData),
    .ALUResult (ALUResult),
    .MemWrite  (MemWrite)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 7'b0010011);
  endfunction

  task automatic load_rom();
    for (int i = 0; i < 64; i++)
      dut.imem[i[5:0]] = (i < prog.size()) ? prog[i] : HALT;
  endtask

  task automatic start_prog();
    @(posedge clk); #1;
    rst = 1'b0;
    load_rom();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (MemWrite === 1'b1) obs_q.push_back(store_t'{ALUResult, WriteData});
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    store_t e, o;
    prog = '{enc_s(8, 0, 0)};
    @(posedge clk); #1;
    rst = 1'b0;
    load_rom();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b0) begin
      errors++; $display("FAIL reset_memwrite: got %b expected 0", MemWrite);
    end
    checks++;
    if (ALUResult !== 32'd8) begin
      errors++; $display("FAIL reset_fetch0: ALUResult got %h expected 00000008", ALUResult);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(store_t'{32'd8, 32'd0});
    run_cycles(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL reset_store: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL reset_extra: got %0d stray stores expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_addi_chain();
    store_t e, o;
    prog = '{addi(1, 0, 5), addi(2, 0, -3), enc_r(0, 2, 1, 0, 3), enc_s(0, 3, 0)};
    exp_q.push_back(store_t'{32'd0, 32'd2});
    start_prog();
    run_cycles(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL addi_chain_store: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL addi_chain_extra: got %0d stray stores expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_slt_sub();
    store_t e, o;
    prog = '{addi(1, 0, 3), addi(2, 0, 7),
             enc_r(0, 2, 1, 2, 4),            // slt x4,x1,x2
             enc_r(32, 2, 1, 0, 5),           // sub x5,x1,x2
             enc_s(4, 4, 0), enc_s(8, 5, 0),
             enc_r(0, 1, 5, 2, 6),            // slt x6,x5,x1 (-4 < 3)
             enc_i(-1, 1, 2, 7, 7'b0010011),  // slti x7,x1,-1
             enc_s(12, 6, 0), enc_s(16, 7, 0)};
    exp_q.push_back(store_t'{32'd4, 32'd1});
    exp_q.push_back(store_t'{32'd8, 32'hFFFFFFFC});
    exp_q.push_back(store_t'{32'd12, 32'd1});
    exp_q.push_back(store_t'{32'd16, 32'd0});
    start_prog();
    run_cycles(14);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL slt_sub_store: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL slt_sub_extra: got %0d stray stores expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_beq();
    store_t e, o;
    prog = '{addi(1, 0, 5), addi(2, 0, 5), addi(3, 0, 6),
             enc_b(8, 2, 1),     // taken: skips the next store
             enc_s(12, 1, 0),
             enc_b(8, 3, 1),     // not taken
             enc_s(16, 1, 0)};
    exp_q.push_back(store_t'{32'd16, 32'd5});
    start_prog();
    run_cycles(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL beq_store: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL beq_extra: got %0d stray stores expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_jal_x0();
    store_t e, o;
    prog = '{NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP,
             enc_j(8, 1),        // 0x20: jal x1,+8
             enc_s(60, 0, 0),    // 0x24: skipped
             enc_s(32, 1, 0),    // 0x28
             addi(0, 0, 9),
             enc_s(36, 0, 0)};
    exp_q.push_back(store_t'{32'd32, 32'h24});
    exp_q.push_back(store_t'{32'd36, 32'd0});
    start_prog();
    run_cycles(18);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL jal_x0_store: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL jal_x0_extra: got %0d stray stores expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_logic_mem();
    store_t e, o;
    logic [31:0] lui_val;
`ifdef RV_LUI_EN
    lui_val = 32'h12345000;
`else
    lui_val = 32'd7;
`endif
    prog = '{addi(1, 0, 32'h0F0),
             enc_i(32'h00F, 1, 6, 2, 7'b0010011),  // ori  x2,x1,0x0F
             enc_i(32'h03C, 2, 7, 3, 7'b0010011),  // andi x3,x2,0x3C
             enc_r(0, 3, 1, 7, 4),                  // and  x4,x1,x3
             enc_r(0, 3, 1, 6, 5),                  // or   x5,x1,x3
             enc_s(0, 4, 0),
             enc_s(260, 5, 0),                      // wraps onto word 1
             enc_i(4, 0, 2, 6, 7'b0000011),         // lw x6,4(x0)
             enc_s(8, 6, 0),
             addi(7, 0, 7),
             32'hFFFFFFFF,                          // unknown opcode
             32'h123453B7,                          // lui x7,0x12345
             enc_s(12, 7, 0),
             enc_r(0, 1, 1, 1, 7),                  // sll: unsupported
             enc_s(16, 7, 0)};
    exp_q.push_back(store_t'{32'd0, 32'h30});
    exp_q.push_back(store_t'{32'd260, 32'hFC});
    exp_q.push_back(store_t'{32'd8, 32'hFC});
    exp_q.push_back(store_t'{32'd12, lui_val});
    exp_q.push_back(store_t'{32'd16, lui_val});
    start_prog();
    run_cycles(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL logic_mem_store: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL logic_mem_extra: got %0d stray stores expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_reference();
    store_t e, o;
    prog = '{32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233,
             32'h0041F2B3, 32'h004282B3, 32'h02728863, 32'h0041A233,
             32'h00020463, 32'h00000293, 32'h0023A233, 32'h005203B3,
             32'h402383B3, 32'h0471AA23, 32'h06002103, 32'h005104B3,
             32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
             32'h00210063};
    exp_q.push_back(store_t'{32'd96, 32'd7});
    exp_q.push_back(store_t'{32'd100, 32'd25});
    start_prog();
    run_cycles(30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL reference_store: got %0d/%0d expected %0d/%0d", o.addr, o.data, e.addr, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL reference_extra: got %0d stray stores expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    store_t e, o;
    prog = '{addi(1, 0, 32'h55), enc_s(44, 1, 0), addi(1, 0, 32'h66), enc_s(44, 1, 0)};
    exp_q.push_back(store_t'{32'd44, 32'h55});
    exp_q.push_back(store_t'{32'd44, 32'h55});
    exp_q.push_back(store_t'{32'd44, 32'h66});
    start_prog();
    run_cycles(3);
    rst = 1'b0;                       // lands on the second sw
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b0) begin
      errors++; $display("FAIL reset_mid_memwrite: got %b expected 0", MemWrite);
    end
    @(posedge clk); #1;
    checks++;
    if (dut.dmem[6'd11] !== 32'h55) begin
      errors++; $display("FAIL reset_mid_mem: got %h expected 00000055", dut.dmem[6'd11]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ALUResult !== 32'h55) begin
      errors++; $display("FAIL reset_mid_restart: ALUResult got %h expected 00000055", ALUResult);
    end
    @(posedge clk); #1;
    run_cycles(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL reset_mid_store: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL reset_mid_extra: got %0d stray stores expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi_chain();
    test_slt_sub();
    test_beq();
    test_jal_x0();
    test_logic_mem();
    test_reference();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port WriteData, output, 32 bits: register rs2 value, i.e. the store data.
REQ-004 SHALL have port ALUResult, output, 32 bits: ALU output, which is the data-memory byte address for loads and stores.
REQ-005 SHALL have port MemWrite, output, 1 bit: high during the cycle a store commits to data memory.

Function
REQ-006 SHALL be a single-cycle RV32I-subset core: one instruction fetched, executed and retired per clk cycle.
REQ-007 SHALL support: lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal.
REQ-008 SHALL hold a 64x32 instruction ROM read combinationally at PC[7:2], initialised with $readmemh from "riscvtest.txt".
REQ-009 SHALL hold a 64x32 data RAM:
- read combinationally at ALUResult[7:2];
- written at the rising edge when MemWrite=1;
- address bits above [7:2] ignored, so addresses wrap modulo 256.
REQ-010 SHALL hold 32x32 registers:
- two combinational read ports, one write port at the rising edge;
- x0 always reads 0 and writes to it are discarded.
REQ-011 SHALL encode ALUControl as 3 bits: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed); other codes produce 0.
REQ-012 SHALL set Zero = (ALU result == 0).
REQ-013 SHALL compute immediates by type, sign-extended from bit 31:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
REQ-014 SHALL select the register writeback value (ResultSrc): 00 ALUResult, 01 memory read data, 10 PC+4.
REQ-015 SHALL compute next PC as PC+imm for jal, and for beq when Zero=1; otherwise PC+4, with 32-bit wrap-around.
REQ-016 SHALL select R-type sub when funct7[5]=1; I-type arithmetic ignores funct7[5].
REQ-017 SHALL treat any unsupported opcode or funct as a NOP: no register write, MemWrite=0, PC+4.
REQ-018 SHALL leave WriteData and ALUResult purely combinational from the current instruction and register contents.

Reset
REQ-019 SHALL set PC to 0x00000000 on a rising clk edge while rst=0.
REQ-020 SHALL force MemWrite=0 and suppress all register-file and data-memory writes while rst=0.
REQ-021 SHALL NOT clear register-file or data-memory contents on reset.
REQ-022 SHALL fetch address 0 on the first edge after rst returns to 1; asserting reset mid-program aborts the current instruction with no side effects.

Configuration
REQ-023 SHALL, with macro RV_LUI_EN defined, decode lui (opcode 0110111):
- rd <= {instr[31:12], 12'b0};
- U immediate routed through the ALU as ALUResult.
REQ-024 SHALL, without RV_LUI_EN, treat opcode 0110111 as a NOP per REQ-017.

Structure
REQ-025 SHALL place in a shared package:
- opcode constants;
- ALUControl, ImmSrc (00 I, 01 S, 10 B, 11 J) and ResultSrc encodings;
- memory depth constant (64).
REQ-026 SHALL split decoding into one sub-module, riscv_controller (opcode/funct3/funct7 to control signals); the datapath and memories stay in top.

Verification
REQ-027 SHALL cover reference program: rst=0 for 2 cycles then 1, run the standard riscvtest.txt.
- First store has ALUResult=96.
- Final store has ALUResult=100, WriteData=25.
- No other store occurs.
REQ-028 SHALL cover addi/add chain: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sw x3,0(x0) -> store with ALUResult=0, WriteData=2.
REQ-029 SHALL cover slt/sub: x1=3, x2=7; slt x4,x1,x2; sub x5,x1,x2; sw x4,4 and sw x5,8 -> WriteData 1 then 0xFFFFFFFC.
REQ-030 SHALL cover beq: taken branch skips sw x1,12(x0) and a not-taken branch falls through -> only the expected store appears at ALUResult=16.
REQ-031 SHALL cover jal and x0: jal x1,+8 at PC=0x20 -> x1=0x24, PC=0x28; addi x0,x0,9 then sw x0 -> WriteData=0.
REQ-032 SHALL cover reset mid-program: rst=0 during a sw cycle -> MemWrite=0 and memory unchanged; restart fetches PC=0.
